// File: rtl/hid_pkg.sv
// hid_pkg: shared states, key constants and slot-array type for the HID report assembler
package hid_pkg;
  localparam int REPORT_BYTES = 8;
  localparam int KEY_SLOTS = 6;
  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, COMMIT, DIFF_REL, DIFF_PRESS} state_t;
  typedef logic [KEY_SLOTS-1:0][7:0] slots_t;
endpackage

// File: rtl/hid_slot_match.sv
// hid_slot_match: flags whether code_i appears in any of the six slots_i (combinational)
module hid_slot_match
  import hid_pkg::*;
(
  input  logic [7:0] code_i,
  input  slots_t     slots_i,
  output logic       present_o
);
  always_comb begin
    present_o = 1'b0;
    for (int i = 0; i < KEY_SLOTS; i++) present_o = present_o | (slots_i[i] == code_i);
  end
endmodule

// File: rtl/hid_report_assembler.sv
// hid_report_assembler: collects boot keyboard report bytes into keycode/modifiers, rejects rollover reports, streams press/release events
module hid_report_assembler
  import hid_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  input  logic             byte_first,
  output logic             byte_ready,
  output logic [63:0]      keycode,
  output logic [7:0]       modifiers,
  output logic             report_strobe,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_press,
  input  logic             evt_ready,
  output logic [ERR_W-1:0] err_count
);
  state_t state_q;
  logic [2:0] idx_q, slot_q;
  logic [7:0] stg_mod_q, mod_q, evt_code_q;
  slots_t stg_q, cur_q, prev_q, other;
  logic strobe_q, evt_valid_q, evt_press_q;
  logic [ERR_W-1:0] err_q;
  logic accept, is_rel, present, emit, step, last_slot, rollover;
  logic [7:0] probe;
  assign byte_ready = state_q == IDLE || state_q == COLLECT;
  assign accept = byte_valid && byte_ready;
  assign is_rel = state_q == DIFF_REL;
  assign probe = is_rel ? prev_q[slot_q] : cur_q[slot_q];
  assign other = is_rel ? cur_q : prev_q;
  assign emit = probe != KEY_NONE && !present;
  // Hold the slot while an event is pending; otherwise move on once nothing needs emitting here.
  assign step = evt_valid_q ? evt_ready : !emit;
  assign last_slot = slot_q == 3'(KEY_SLOTS - 1);
  hid_slot_match u_match (
    .code_i   (probe),
    .slots_i  (other),
    .present_o(present)
  );
  always_comb begin
    rollover = 1'b0;
    for (int i = 0; i < KEY_SLOTS; i++) rollover = rollover | (stg_q[i] == KEY_ERR_ROLLOVER);
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      slot_q <= '0;
      stg_mod_q <= '0;
      stg_q <= '0;
      cur_q <= '0;
      prev_q <= '0;
      mod_q <= '0;
      strobe_q <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_code_q <= '0;
      evt_press_q <= 1'b0;
      err_q <= '0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: if (accept && byte_first) begin
          stg_mod_q <= byte_data;
          idx_q <= 3'd1;
          state_q <= COLLECT;
        end
        COLLECT: if (accept) begin
          if (byte_first) begin
            stg_mod_q <= byte_data;
            idx_q <= 3'd1;
          end else begin
            if (idx_q >= 3'd2) stg_q[idx_q-3'd2] <= byte_data;
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'(REPORT_BYTES - 1)) state_q <= CHECK;
          end
        end
        CHECK: begin
          if (rollover && ~&err_q) err_q <= err_q + ERR_W'(1);
          state_q <= rollover ? IDLE : COMMIT;
        end
        COMMIT: begin
          cur_q <= stg_q;
          mod_q <= stg_mod_q;
          strobe_q <= 1'b1;
          slot_q <= '0;
          state_q <= DIFF_REL;
        end
        DIFF_REL, DIFF_PRESS: begin
          if (evt_valid_q && evt_ready) evt_valid_q <= 1'b0;
          if (!evt_valid_q && emit) begin
            evt_valid_q <= 1'b1;
            evt_code_q <= probe;
            evt_press_q <= !is_rel;
          end
          if (step) begin
            slot_q <= last_slot ? 3'd0 : slot_q + 3'd1;
            if (last_slot && is_rel) state_q <= DIFF_PRESS;
            if (last_slot && !is_rel) begin
              prev_q <= cur_q;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign keycode = {16'h0000, cur_q};
  assign modifiers = mod_q;
  assign report_strobe = strobe_q;
  assign evt_valid = evt_valid_q;
  assign evt_code = evt_code_q;
  assign evt_press = evt_press_q;
  assign err_count = err_q;
endmodule
